// File: rtl/branch_predictor_if.sv
// branch_predictor_if
// Groups the IF-side lookup and the EX-side training bus of the branch predictor.
//   pc_IF          : PC of the instruction currently being decoded (lookup index source)
//   predict        : taken/not-taken prediction for pc_IF
//   update_en      : EX resolved a real conditional branch this cycle
//   update_pc      : PC of the resolving branch
//   update_taken   : actual outcome of the resolving branch
//   update_predict : prediction that travelled down the pipe with that branch
// master = pipeline side (drives PCs and training), slave = predictor.
interface branch_predictor_if;
  logic [31:0] pc_IF;
  logic        predict;
  logic        update_en;
  logic [31:0] update_pc;
  logic        update_taken;
  logic        update_predict;

  modport master (
    output pc_IF, update_en, update_pc, update_taken, update_predict,
    input  predict
  );

  modport slave (
    input  pc_IF, update_en, update_pc, update_taken, update_predict,
    output predict
  );
endinterface

// File: rtl/branch_predictor.sv
// branch_predictor
// Bimodal conditional-branch predictor: a table of 2-bit saturating counters
// indexed by pc[INDEX_BITS+1:2], plus saturating branch/mispredict statistics.
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   bus             : lookup + training bus (branch_predictor_if.slave)
//   bht_addr_debug  : debug read index into the counter table
//   bht_data_debug  : counter value at bht_addr_debug (combinational, pre-update)
//   branch_cnt      : resolved conditional branches since reset (saturating)
//   mispredict_cnt  : resolved branches whose outcome differed from the prediction
module branch_predictor #(
  parameter int         INDEX_BITS = 6,
  parameter logic [1:0] INIT_STATE = 2'b01
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_predictor_if.slave     bus,
  input  logic [INDEX_BITS-1:0] bht_addr_debug,
  output logic [1:0]            bht_data_debug,
  output logic [31:0]           branch_cnt,
  output logic [31:0]           mispredict_cnt
);

  localparam int ENTRIES = 2 ** INDEX_BITS;

  logic [1:0]            bht [ENTRIES];
  logic [INDEX_BITS-1:0] read_idx;
  logic [INDEX_BITS-1:0] update_idx;

  // Word-aligned PCs: the low two bits and everything above the index are
  // deliberately ignored, so distinct branches may alias onto one counter.
  assign read_idx   = bus.pc_IF[INDEX_BITS+1:2];
  assign update_idx = bus.update_pc[INDEX_BITS+1:2];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.pc_IF[31:INDEX_BITS+2], bus.pc_IF[1:0],
                            bus.update_pc[31:INDEX_BITS+2], bus.update_pc[1:0]};

  // Reads come straight from the registers, so a same-cycle update to the
  // same entry is not bypassed: the new value appears the following cycle.
  assign bus.predict    = bht[read_idx][1];
  assign bht_data_debug = bht[bht_addr_debug];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bht[i] <= INIT_STATE;
      end
    end else if (bus.update_en) begin
      if (bus.update_taken) begin
        if (bht[update_idx] != 2'b11) begin
          bht[update_idx] <= bht[update_idx] + 2'b01;
        end
      end else begin
        if (bht[update_idx] != 2'b00) begin
          bht[update_idx] <= bht[update_idx] - 2'b01;
        end
      end
    end
  end

  // Statistics stick at all-ones rather than wrapping, so a long run never
  // reports a misleadingly small count.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt     <= 32'd0;
      mispredict_cnt <= 32'd0;
    end else if (bus.update_en) begin
      if (branch_cnt != 32'hFFFF_FFFF) begin
        branch_cnt <= branch_cnt + 32'd1;
      end
      if ((bus.update_taken != bus.update_predict) &&
          (mispredict_cnt != 32'hFFFF_FFFF)) begin
        mispredict_cnt <= mispredict_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor
// Self-checking bench for branch_predictor: directed vector table, hand-written
// reset/saturation sequences, and a randomized run against a reference model.
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [5:0]  bht_addr_debug;
  logic [1:0]  bht_data_debug;
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;

  branch_predictor_if bif ();

  branch_predictor #(.INDEX_BITS(6), .INIT_STATE(2'b01)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bif.slave),
    .bht_addr_debug (bht_addr_debug),
    .bht_data_debug (bht_data_debug),
    .branch_cnt     (branch_cnt),
    .mispredict_cnt (mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          en;
    logic [31:0] upc;
    bit          taken;
    bit          upred;
    logic [31:0] pcif;
    logic [5:0]  dbg;
    bit          pred_now;
    bit          pred_next;
    logic [1:0]  dbg_now;
    logic [1:0]  dbg_next;
  } vec_t;

  vec_t vecs[9];

  // Reference model: counters held as plain integers 0..3, statistics as wide ints.
  int      model_bht[64];
  longint  model_branches;
  longint  model_mispredicts;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Drives one cycle's inputs at the falling edge so they are stable at the next rising edge.
  task automatic applyStimulus(input bit en, input logic [31:0] upc, input bit taken,
                               input bit upred, input logic [31:0] pcif, input logic [5:0] dbg);
    @(negedge clk);
    bif.update_en      = en;
    bif.update_pc      = upc;
    bif.update_taken   = taken;
    bif.update_predict = upred;
    bif.pc_IF          = pcif;
    bht_addr_debug     = dbg;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst           = 1'b1;
    bif.update_en = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 64; i++) model_bht[i] = 1;
    model_branches    = 0;
    model_mispredicts = 0;
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'(pc[7:2]);
  endfunction

  initial begin
    rst                = 1'b1;
    bif.pc_IF          = 32'h0;
    bif.update_en      = 1'b0;
    bif.update_pc      = 32'h0;
    bif.update_taken   = 1'b0;
    bif.update_predict = 1'b0;
    bht_addr_debug     = 6'd0;

    // Entry 16 = pc 0x40 (alias 0x140), entry 32 = pc 0x80.
    vecs[0] = '{1'b1, 32'h40,  1'b1, 1'b0, 32'h40,  6'd16, 1'b0, 1'b1, 2'b01, 2'b10};
    vecs[1] = '{1'b1, 32'h40,  1'b1, 1'b1, 32'h40,  6'd16, 1'b1, 1'b1, 2'b10, 2'b11};
    vecs[2] = '{1'b1, 32'h40,  1'b1, 1'b1, 32'h40,  6'd16, 1'b1, 1'b1, 2'b11, 2'b11};
    vecs[3] = '{1'b1, 32'h40,  1'b0, 1'b1, 32'h140, 6'd16, 1'b1, 1'b1, 2'b11, 2'b10};
    vecs[4] = '{1'b1, 32'h40,  1'b0, 1'b1, 32'h40,  6'd16, 1'b1, 1'b0, 2'b10, 2'b01};
    vecs[5] = '{1'b1, 32'h40,  1'b0, 1'b0, 32'h140, 6'd16, 1'b0, 1'b0, 2'b01, 2'b00};
    vecs[6] = '{1'b1, 32'h40,  1'b0, 1'b0, 32'h40,  6'd16, 1'b0, 1'b0, 2'b00, 2'b00};
    vecs[7] = '{1'b1, 32'h80,  1'b1, 1'b0, 32'h80,  6'd32, 1'b0, 1'b1, 2'b01, 2'b10};
    vecs[8] = '{1'b0, 32'h80,  1'b0, 1'b0, 32'h80,  6'd32, 1'b1, 1'b1, 2'b10, 2'b10};

    doReset();

    // Reset state
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h40, 6'd16);
    #1;
    checkOutput("reset_predict", {31'b0, bif.predict}, 32'd0);
    checkOutput("reset_dbg16", {30'b0, bht_data_debug}, 32'd1);
    checkOutput("reset_branch_cnt", branch_cnt, 32'd0);
    checkOutput("reset_mispredict_cnt", mispredict_cnt, 32'd0);

    // Directed vector table
    for (int v = 0; v < 9; v++) begin
      applyStimulus(vecs[v].en, vecs[v].upc, vecs[v].taken, vecs[v].upred, vecs[v].pcif, vecs[v].dbg);
      #1;
      checkOutput($sformatf("vec%0d_pred_now", v), {31'b0, bif.predict}, {31'b0, vecs[v].pred_now});
      checkOutput($sformatf("vec%0d_dbg_now", v), {30'b0, bht_data_debug}, {30'b0, vecs[v].dbg_now});
      @(posedge clk);
      #1;
      bif.update_en = 1'b0;
      #1;
      checkOutput($sformatf("vec%0d_pred_next", v), {31'b0, bif.predict}, {31'b0, vecs[v].pred_next});
      checkOutput($sformatf("vec%0d_dbg_next", v), {30'b0, bht_data_debug}, {30'b0, vecs[v].dbg_next});
    end
    checkOutput("table_branch_cnt", branch_cnt, 32'd8);
    checkOutput("table_mispredict_cnt", mispredict_cnt, 32'd4);

    // Reset wins over a simultaneous update
    @(negedge clk);
    rst                = 1'b1;
    bif.update_en      = 1'b1;
    bif.update_pc      = 32'h40;
    bif.update_taken   = 1'b1;
    bif.update_predict = 1'b0;
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bif.update_en = 1'b0;
    bht_addr_debug = 6'd16;
    bif.pc_IF      = 32'h80;
    #1;
    checkOutput("rst_upd_dbg16", {30'b0, bht_data_debug}, 32'd1);
    checkOutput("rst_upd_pred80", {31'b0, bif.predict}, 32'd0);
    checkOutput("rst_upd_branch_cnt", branch_cnt, 32'd0);
    checkOutput("rst_upd_mispredict_cnt", mispredict_cnt, 32'd0);

    // Statistics saturation
    @(negedge clk);
    force dut.branch_cnt = 32'hFFFF_FFFE;
    force dut.mispredict_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.branch_cnt;
    release dut.mispredict_cnt;
    #1;
    checkOutput("sat_preload", branch_cnt, 32'hFFFF_FFFE);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 32'h40, 6'd16);
      @(posedge clk);
      #1;
      bif.update_en = 1'b0;
      if (k >= 1) begin
        checkOutput($sformatf("sat%0d_branch_cnt", k), branch_cnt, 32'hFFFF_FFFF);
        checkOutput($sformatf("sat%0d_mispredict_cnt", k), mispredict_cnt, 32'hFFFF_FFFF);
      end
    end

    // Randomized run against the reference model
    doReset();
    for (int c = 0; c < 400; c++) begin
      logic [31:0] upc;
      logic [31:0] pcif;
      logic [5:0]  dbg;
      bit          en;
      bit          taken;
      bit          upred;
      int          ui;
      en    = ($urandom_range(0, 3) != 0);
      upc   = $urandom_range(0, 32'h3FF);
      pcif  = ($urandom_range(0, 1) == 1) ? upc : 32'($urandom_range(0, 32'h3FF));
      dbg   = 6'($urandom_range(0, 63));
      taken = ($urandom_range(0, 2) != 0);
      upred = 1'($urandom_range(0, 1));
      applyStimulus(en, upc, taken, upred, pcif, dbg);
      #1;
      checkOutput("rand_predict", {31'b0, bif.predict}, (model_bht[idx_of(pcif)] >= 2) ? 32'd1 : 32'd0);
      checkOutput("rand_dbg", {30'b0, bht_data_debug}, 32'(model_bht[int'(dbg)]));
      @(posedge clk);
      if (en) begin
        ui = idx_of(upc);
        if (taken) model_bht[ui] = (model_bht[ui] == 3) ? 3 : model_bht[ui] + 1;
        else       model_bht[ui] = (model_bht[ui] == 0) ? 0 : model_bht[ui] - 1;
        model_branches++;
        if (taken != upred) model_mispredicts++;
      end
      #1;
      checkOutput("rand_branch_cnt", branch_cnt, 32'(model_branches));
      checkOutput("rand_mispredict_cnt", mispredict_cnt, 32'(model_mispredicts));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
